qspi_cmd_sequencer: RTL and testbench
=====================================

Name: qspi_cmd_sequencer

Overview:
Front-end controller that owns the 4-bit serial link (sck, cs_n, sdi[3:0], sdo[3:0]) and sequences the chess search core. It oversamples the link in the clk domain, assembles nibbles into command frames, and writes board squares into the core's board store. It starts searches and returns status and best-move results to the host. It is the only master of the core's board write port and start strobe.

Parameters:
SYNC_STAGES, 2, flops in the sck/cs_n/sdi synchronizer chain (min 2)
SQ_BITS, 6, board square address width (64 squares)
PC_BITS, 4, piece code width per square

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sck  in  1  serial clock from host, asynchronous to clk
cs_n  in  1  frame select, active-low, asynchronous
sdi  in  4  serial data nibble from host
sdo  out  4  serial data nibble to host
sdo_oe  out  1  drive enable for sdo
brd_we  out  1  one-cycle board write strobe
brd_addr  out  SQ_BITS  board write address
brd_data  out  PC_BITS  board write data
core_start  out  1  one-cycle search start pulse
core_busy  in  1  search core running
core_done  in  1  one-cycle search-complete pulse
res_from  in  SQ_BITS  best-move source square, valid when core_done
res_to  in  SQ_BITS  best-move destination square, valid when core_done

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0. FSM=IDLE. Sticky flags and result registers cleared. Takes priority over every other event.
- sck, cs_n and sdi each pass through SYNC_STAGES flops. The sck rise/fall is detected from the last two synchronized samples.
- Sampling: sdi is captured on a synchronized sck rise. The high nibble of each byte comes first. A byte completes every 2nd rise.
- Drive: sdo updates on a synchronized sck fall. sdo_oe=1 only in RESP with cs_n low, otherwise sdo=0.
- Synchronized cs_n high at any time: FSM returns to IDLE, nibble/byte counters clear, and sdo_oe=0 on the next clk. A partial byte is discarded and any pending arg write is dropped.
- FSM states:
  - IDLE: first byte is the opcode.
    - 0x01 WR_SQ -> ARG.
    - 0x02 START -> if core_busy=0, pulse core_start for exactly 1 clk and go to DONE. If core_busy=1, set err_sticky and go to DONE.
    - 0x03 RD_STATUS -> RESP, 1 byte.
    - 0x04 RD_RESULT -> RESP, 2 bytes.
    - any other opcode -> set err_sticky, go to DONE.
  - ARG: collects 2 bytes, addr then data.
    - brd_addr=addr[SQ_BITS-1:0], brd_data=data[PC_BITS-1:0].
    - brd_we pulses 1 clk, 1 clk after the 2nd byte completes. Upper bits are ignored.
    - WR_SQ while core_busy=1: no write, set err_sticky.
    - Then go to DONE.
  - RESP: shifts response bytes out, high nibble first.
    - The first nibble is driven on the sck fall after the opcode's last rise.
    - Status byte = {5'b0, err_sticky, done_sticky, core_busy}.
    - Result = {2'b0, res_from_q}, then {2'b0, res_to_q}.
    - After the last nibble, go to DONE.
    - RD_STATUS clears err_sticky on completion. RD_RESULT clears done_sticky on completion.
    - The response byte is snapshotted at the opcode's completion.
  - DONE: ignores further sck edges until cs_n rises.
- On core_done: latch res_from/res_to and set done_sticky.
  - If core_done coincides with a done_sticky clear in the same clk, set wins.
- core_start is never asserted while core_busy=1. At most one start per frame.
- Response latency: host sees the first response nibble on the first sck fall after the opcode. sck must be ≤ clk/4.

Test Plan:
- Reset with sck toggling and cs_n=0 -> all outputs 0 during reset. First frame after deassert decodes normally.
- Frame 0x01,0x1C,0x05 with core_busy=0 -> single brd_we pulse with brd_addr=28, brd_data=5. No core_start.
- Frame 0x02 with core_busy=0 -> exactly one core_start pulse. Repeat with core_busy=1 -> no pulse. Following RD_STATUS returns 0x05 (err=1, busy=1), and a second RD_STATUS returns 0x01.
- core_done with res_from=12, res_to=28, then RD_STATUS -> 0x02. RD_RESULT -> nibbles 0,C,1,C. Next RD_STATUS -> 0x00.
- Abort: cs_n raised after 3 nibbles of WR_SQ -> no brd_we. Next frame 0x03 decodes correctly and sdo_oe drops within SYNC_STAGES+1 clk of cs_n rise.
- Unknown opcode 0xA7, then RD_STATUS -> status bit2 set. Extra sck edges in DONE produce no strobes.

Source files
------------

// File: rtl/qspi_cmd_sequencer.sv
// Host-facing 4-bit serial command front end: decodes opcode frames, writes board squares,
// starts the search core and returns status / best-move bytes on sdo.
module qspi_cmd_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int SQ_BITS     = 6,
    parameter int PC_BITS     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sck,
    input  logic               cs_n,
    input  logic [3:0]         sdi,
    output logic [3:0]         sdo,
    output logic               sdo_oe,
    output logic               brd_we,
    output logic [SQ_BITS-1:0] brd_addr,
    output logic [PC_BITS-1:0] brd_data,
    output logic               core_start,
    input  logic               core_busy,
    input  logic               core_done,
    input  logic [SQ_BITS-1:0] res_from,
    input  logic [SQ_BITS-1:0] res_to
);

    localparam logic [7:0] OP_WR_SQ     = 8'h01;
    localparam logic [7:0] OP_START     = 8'h02;
    localparam logic [7:0] OP_RD_STATUS = 8'h03;
    localparam logic [7:0] OP_RD_RESULT = 8'h04;

    typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_RESP, ST_DONE} state_t;

    logic [SYNC_STAGES-1:0]      sck_sync_q, cs_sync_q;
    logic [SYNC_STAGES-1:0][3:0] sdi_sync_q;
    logic                        sck_prev_q;
    logic                        sck_s, cs_s, sck_rise, sck_fall;
    logic [3:0]                  sdi_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            sck_prev_q <= sck_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    state_t               state_q, state_d;
    logic                 nib_q, nib_d;
    logic [3:0]           hi_q, hi_d;
    logic                 arg_cnt_q, arg_cnt_d;
    logic [SQ_BITS-1:0]   addr_q, addr_d;
    logic                 brd_we_q, brd_we_d;
    logic [SQ_BITS-1:0]   brd_addr_q, brd_addr_d;
    logic [PC_BITS-1:0]   brd_data_q, brd_data_d;
    logic                 core_start_q, core_start_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [SQ_BITS-1:0]   res_from_q, res_to_q;
    logic [15:0]          resp_q, resp_d;
    logic [2:0]           left_q, left_d;
    logic                 is_res_q, is_res_d;
    logic [3:0]           sdo_q, sdo_d;
    logic                 byte_done;
    logic [7:0]           byte_val;

    assign byte_val = {hi_q, sdi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            nib_q        <= 1'b0;
            hi_q         <= '0;
            arg_cnt_q    <= 1'b0;
            addr_q       <= '0;
            brd_we_q     <= 1'b0;
            brd_addr_q   <= '0;
            brd_data_q   <= '0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            res_from_q   <= '0;
            res_to_q     <= '0;
            resp_q       <= '0;
            left_q       <= '0;
            is_res_q     <= 1'b0;
            sdo_q        <= '0;
        end else begin
            state_q      <= state_d;
            nib_q        <= nib_d;
            hi_q         <= hi_d;
            arg_cnt_q    <= arg_cnt_d;
            addr_q       <= addr_d;
            brd_we_q     <= brd_we_d;
            brd_addr_q   <= brd_addr_d;
            brd_data_q   <= brd_data_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
            done_q       <= done_d;
            resp_q       <= resp_d;
            left_q       <= left_d;
            is_res_q     <= is_res_d;
            sdo_q        <= sdo_d;
            if (core_done) begin
                res_from_q <= res_from;
                res_to_q   <= res_to;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        nib_d        = nib_q;
        hi_d         = hi_q;
        arg_cnt_d    = arg_cnt_q;
        addr_d       = addr_q;
        brd_we_d     = 1'b0;
        brd_addr_d   = brd_addr_q;
        brd_data_d   = brd_data_q;
        core_start_d = 1'b0;
        err_d        = err_q;
        done_d       = done_q | core_done;
        resp_d       = resp_q;
        left_d       = left_q;
        is_res_d     = is_res_q;
        sdo_d        = sdo_q;
        byte_done    = 1'b0;

        if (cs_s) begin
            // Frame boundary: partial bytes and unfinished arguments are discarded.
            state_d   = ST_IDLE;
            nib_d     = 1'b0;
            arg_cnt_d = 1'b0;
        end else begin
            if (sck_rise && (state_q == ST_IDLE || state_q == ST_ARG)) begin
                if (!nib_q) begin
                    hi_d  = sdi_s;
                    nib_d = 1'b1;
                end else begin
                    nib_d     = 1'b0;
                    byte_done = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (byte_done) begin
                        case (byte_val)
                            OP_WR_SQ: begin
                                state_d   = ST_ARG;
                                arg_cnt_d = 1'b0;
                            end
                            OP_START: begin
                                if (!core_busy) core_start_d = 1'b1;
                                else            err_d        = 1'b1;
                                state_d = ST_DONE;
                            end
                            OP_RD_STATUS: begin
                                resp_d   = {5'b0, err_q, done_q, core_busy, 8'h00};
                                left_d   = 3'd2;
                                is_res_d = 1'b0;
                                sdo_d    = 4'h0;
                                state_d  = ST_RESP;
                            end
                            OP_RD_RESULT: begin
                                resp_d   = {8'(res_from_q), 8'(res_to_q)};
                                left_d   = 3'd4;
                                is_res_d = 1'b1;
                                sdo_d    = 4'h0;
                                state_d  = ST_RESP;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = ST_DONE;
                            end
                        endcase
                    end
                end
                ST_ARG: begin
                    if (byte_done) begin
                        if (!arg_cnt_q) begin
                            addr_d    = byte_val[SQ_BITS-1:0];
                            arg_cnt_d = 1'b1;
                        end else begin
                            if (!core_busy) begin
                                brd_we_d   = 1'b1;
                                brd_addr_d = addr_q;
                                brd_data_d = byte_val[PC_BITS-1:0];
                            end else begin
                                err_d = 1'b1;
                            end
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_RESP: begin
                    if (sck_fall && left_q != 3'd0) begin
                        sdo_d  = resp_q[15:12];
                        resp_d = {resp_q[11:0], 4'h0};
                        left_d = left_q - 3'd1;
                    end
                    // The host samples the last nibble on this rise; only then is the read complete.
                    if (sck_rise && left_q == 3'd0) begin
                        state_d = ST_DONE;
                        if (is_res_q) done_d = core_done;
                        else          err_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sdo_oe     = (state_q == ST_RESP) && !cs_s;
    assign sdo        = sdo_oe ? sdo_q : 4'h0;
    assign brd_we     = brd_we_q;
    assign brd_addr   = brd_addr_q;
    assign brd_data   = brd_data_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Bench for qspi_cmd_sequencer: host-side serial driver, event scoreboard fed by a
// frame-level reference model, and monitors on the board port, start strobe and sdo.
module tb_qspi_cmd_sequencer;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst, sck, cs_n, core_busy, core_done;
    logic [3:0] sdi;
    logic [5:0] res_from, res_to;
    logic [3:0] sdo;
    logic       sdo_oe, brd_we, core_start;
    logic [5:0] brd_addr;
    logic [3:0] brd_data;

    qspi_cmd_sequencer #(.SYNC_STAGES(SYNC), .SQ_BITS(6), .PC_BITS(4)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .brd_we(brd_we), .brd_addr(brd_addr),
        .brd_data(brd_data), .core_start(core_start), .core_busy(core_busy),
        .core_done(core_done), .res_from(res_from), .res_to(res_to)
    );

    always #5 clk = ~clk;

    // Event word: kind in [15:14] (1 = board write, 2 = start, 3 = sdo nibble), payload below.
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    int m_err, m_done, m_from, m_to;
    logic [7:0] frame_b [4];

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    task automatic check_ev(input string name, input logic [15:0] got);
        logic [15:0] want;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected event 0x%04h, none expected", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got === want) n_pass++;
            else $display("FAIL %s: got event 0x%04h expected 0x%04h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (brd_we)     check_ev("brd_we", {2'd1, 4'd0, brd_addr, brd_data});
            if (core_start) check_ev("core_start", {2'd2, 14'd0});
        end
    end

    always @(posedge sck) begin
        if (rst === 1'b0 && sdo_oe) check_ev("sdo", {2'd3, 10'd0, sdo});
    end

    function automatic void push_nib(input int v);
        exp_q.push_back({2'd3, 10'd0, 4'(v % 16)});
    endfunction

    // Frame-level model: what a host should observe given the opcode, how many nibbles
    // were clocked and how many response nibbles were read before cs_n rose.
    task automatic model_frame(input int n_nib, input int n_resp);
        int op, st, res;
        op = frame_b[0];
        if (n_nib < 2) return;
        if (op == 1) begin
            if (n_nib >= 6) begin
                if (core_busy) m_err = 1;
                else exp_q.push_back({2'd1, 4'd0, 6'(frame_b[1] % 64), 4'(frame_b[2] % 16)});
            end
        end else if (op == 2) begin
            if (core_busy) m_err = 1;
            else exp_q.push_back({2'd2, 14'd0});
        end else if (op == 3) begin
            st = 4 * m_err + 2 * m_done + (core_busy ? 1 : 0);
            for (int i = 0; i < n_resp && i < 2; i++) push_nib(st / (i == 0 ? 16 : 1));
            if (n_resp >= 2) m_err = 0;
        end else if (op == 4) begin
            res = m_from * 256 + m_to;
            for (int i = 0; i < n_resp && i < 4; i++) push_nib(res / (4096 >> (4 * i)));
            if (n_resp >= 4) m_done = 0;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic host_nib(input logic [3:0] v);
        sdi = v;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check_val("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_frame(input int n_nib, input int n_resp, input int n_extra);
        model_frame(n_nib, n_resp);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n_nib; i++)
            host_nib(4'((i % 2 == 0) ? frame_b[i / 2] / 16 : frame_b[i / 2] % 16));
        for (int i = 0; i < n_resp + n_extra; i++) host_nib(4'($urandom_range(0, 15)));
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        drain();
    endtask

    task automatic op_frame(input logic [7:0] op, input int n_resp, input int n_extra);
        frame_b[0] = op;
        do_frame(2, n_resp, n_extra);
    endtask

    task automatic pulse_done(input int f, input int t);
        @(negedge clk);
        core_done = 1'b1;
        res_from  = 6'(f);
        res_to    = 6'(t);
        @(negedge clk);
        core_done = 1'b0;
        res_from  = 6'($urandom_range(0, 63));
        res_to    = 6'($urandom_range(0, 63));
        m_done = 1; m_from = f; m_to = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        cs_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sck = ~sck;
            @(negedge clk);
            if (i >= 2)
                check_val("reset_outputs", {sdo, sdo_oe, brd_we, brd_addr, brd_data, core_start}, 0);
        end
        rst  = 1'b0;
        sck  = 1'b0;
        cs_n = 1'b1;
        m_err = 0; m_done = 0; m_from = 0; m_to = 0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, kind, nn, ext;
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = 4'h0;
        core_busy = 1'b0; core_done = 1'b0; res_from = '0; res_to = '0;
        do_reset();

        // Directed: board write, start with and without a busy core, status reads.
        frame_b[0] = 8'h01; frame_b[1] = 8'h1C; frame_b[2] = 8'h05;
        do_frame(6, 0, 0);
        op_frame(8'h02, 0, 0);
        core_busy = 1'b1;
        op_frame(8'h02, 0, 2);
        op_frame(8'h03, 2, 0);
        op_frame(8'h03, 2, 0);
        core_busy = 1'b0;

        pulse_done(12, 28);
        op_frame(8'h03, 2, 0);
        op_frame(8'h04, 4, 0);
        op_frame(8'h03, 2, 0);

        // Abort a board write after three nibbles.
        frame_b[0] = 8'h01; frame_b[1] = 8'h1C; frame_b[2] = 8'h05;
        do_frame(3, 0, 0);

        // Abort a status read mid-response and time the drive-enable release.
        frame_b[0] = 8'h03;
        model_frame(2, 1);
        @(negedge clk); cs_n = 1'b0;
        repeat (4) @(negedge clk);
        host_nib(4'h0); host_nib(4'h3); host_nib(4'h0);
        repeat (HALF) @(negedge clk);
        check_val("sdo_oe_before_abort", sdo_oe, 1);
        cs_n = 1'b1;
        k = 0;
        while (sdo_oe && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("sdo_oe_drop_latency_ok", (k <= SYNC + 1) ? 1 : 0, 1);
        repeat (8) @(negedge clk);
        drain();
        op_frame(8'h03, 2, 0);

        // Unknown opcode with trailing edges, then status shows the error.
        op_frame(8'hA7, 0, 4);
        op_frame(8'h03, 2, 3);
        op_frame(8'hA7, 0, 0);
        pulse_done(63, 0);
        do_reset();
        op_frame(8'h03, 2, 0);
        op_frame(8'h04, 4, 0);

        // Randomized frames against the model.
        for (int it = 0; it < 40; it++) begin
            core_busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) pulse_done($urandom_range(0, 63), $urandom_range(0, 63));
            kind = $urandom_range(0, 5);
            ext  = $urandom_range(0, 2);
            frame_b[1] = 8'($urandom_range(0, 255));
            frame_b[2] = 8'($urandom_range(0, 255));
            case (kind)
                0, 1: begin
                    frame_b[0] = 8'h01;
                    nn = ($urandom_range(0, 1) == 0) ? 6 : $urandom_range(2, 6);
                    do_frame(nn, 0, (nn == 6) ? ext : 0);
                end
                2: op_frame(8'h02, 0, ext);
                3: op_frame(8'h03, 2, ext);
                4: op_frame(8'h04, 4, ext);
                default: begin
                    frame_b[0] = 8'($urandom_range(5, 255));
                    do_frame(2, 0, ext);
                end
            endcase
        end
        core_busy = 1'b0;
        op_frame(8'h03, 2, 0);
        op_frame(8'h04, 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
